div: RTL and testbench

Iterative radix-2 restoring divider for the RV32M execute stage; the inverse counterpart of the pipelined multiplier. It accepts a dividend/divisor pair under the same `req_i`/`flush_i`/`ready_o` handshake the multiplier uses. It produces quotient and remainder with RISC-V DIV/DIVU/REM/REMU semantics, including divide-by-zero and signed-overflow results. Normal operations take XLEN+1 cycles; special cases complete early.

---
 rtl/div.sv | 144 ++++++++++++++
 tb/tb_div.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/div.sv
// div: iterative radix-2 restoring divider for the RV32M execute stage.
// Handles DIV/DIVU/REM/REMU, including divide-by-zero and signed overflow,
// which finish one cycle after accept. Every other operation walks one
// quotient bit per cycle over XLEN iterations.
module div #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            flush_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            ready_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic            r_signed;
  logic            r_quotNeg;
  logic            r_remNeg;
  logic [XLEN-1:0] r_divisor;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_rem;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_quotOut;
  logic [XLEN-1:0] r_remOut;

  // Operand inspection at accept time.
  logic            w_aNeg;
  logic            w_bNeg;
  logic [XLEN-1:0] w_aMag;
  logic [XLEN-1:0] w_bMag;
  logic            w_divByZero;
  logic            w_overflow;

  // One restoring step.
  logic [XLEN:0]   w_remShift;
  logic [XLEN:0]   w_trial;
  logic            w_borrow;
  logic [XLEN-1:0] w_remNext;
  logic [XLEN-1:0] w_quotNext;
  logic [XLEN-1:0] w_quotFinal;
  logic [XLEN-1:0] w_remFinal;

  // The unsigned core works on magnitudes. The sign flags are only ever
  // set for signed operations, and the final negation undoes the
  // magnitude conversion.
  assign w_aNeg      = signed_i & a_i[XLEN-1];
  assign w_bNeg      = signed_i & b_i[XLEN-1];
  assign w_aMag      = w_aNeg ? (-a_i) : a_i;
  assign w_bMag      = w_bNeg ? (-b_i) : b_i;
  assign w_divByZero = (b_i == '0);
  assign w_overflow  = signed_i & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == '1);

  // The partial remainder always stays below the divisor. The shifted value
  // therefore fits in XLEN+1 bits, and the MSB of the XLEN+1-bit difference
  // is exactly the borrow.
  assign w_remShift  = {r_rem, r_quot[XLEN-1]};
  assign w_trial     = w_remShift - {1'b0, r_divisor};
  assign w_borrow    = w_trial[XLEN];
  assign w_remNext   = w_borrow ? w_remShift[XLEN-1:0] : w_trial[XLEN-1:0];
  assign w_quotNext  = {r_quot[XLEN-2:0], ~w_borrow};
  assign w_quotFinal = (r_signed & r_quotNeg) ? (-w_quotNext) : w_quotNext;
  assign w_remFinal  = (r_signed & r_remNeg) ? (-w_remNext) : w_remNext;

  // Sequencing, iteration and result registers, all in one state machine.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= IDLE;
      r_signed  <= 1'b0;
      r_quotNeg <= 1'b0;
      r_remNeg  <= 1'b0;
      r_divisor <= '0;
      r_quot    <= '0;
      r_rem     <= '0;
      r_count   <= '0;
      r_quotOut <= '0;
      r_remOut  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_i && !flush_i) begin
            r_signed  <= signed_i;
            r_quotNeg <= w_aNeg ^ w_bNeg;
            r_remNeg  <= w_aNeg;
            r_divisor <= w_bMag;
            r_quot    <= w_aMag;
            r_rem     <= '0;
            r_count   <= CW'(XLEN);
            if (w_divByZero) begin
              r_quotOut <= '1;
              r_remOut  <= a_i;
              r_state   <= DONE;
            end else if (w_overflow) begin
              r_quotOut <= a_i;
              r_remOut  <= '0;
              r_state   <= DONE;
            end else begin
              r_state   <= BUSY;
            end
          end
        end
        BUSY: begin
          if (flush_i || !req_i) begin
            r_state <= IDLE;
          end else begin
            r_rem   <= w_remNext;
            r_quot  <= w_quotNext;
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_quotOut <= w_quotFinal;
              r_remOut  <= w_remFinal;
              r_state   <= DONE;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Flush or a dropped request in the DONE cycle suppresses the handshake.
  // The result registers have already been written at that point.
  assign ready_o     = (r_state == DONE) & req_i & ~flush_i;
  assign quotient_o  = r_quotOut;
  assign remainder_o = r_remOut;

endmodule

// File: tb/tb_div.sv
// tb_div: directed self-checking bench for the restoring divider.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        flush;
  logic        signedIn;
  logic [31:0] aIn;
  logic [31:0] bIn;
  logic        readyOut;
  logic [31:0] quotOut;
  logic [31:0] remOut;

  int checks = 0;
  int errors = 0;
  int cycleCount = 0;
  int readyAt1;
  int readyAt2;

  div #(.XLEN(32)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .flush_i     (flush),
    .signed_i    (signedIn),
    .a_i         (aIn),
    .b_i         (bIn),
    .ready_o     (readyOut),
    .quotient_o  (quotOut),
    .remainder_o (remOut)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter, used to measure the spacing between ready pulses.
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Single comparison point. A failure is counted and reported.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present an operation. Called just after a rising edge.
  task automatic driveOp(input logic [31:0] a, input logic [31:0] b, input logic s);
    req      = 1'b1;
    aIn      = a;
    bIn      = b;
    signedIn = s;
  endtask

  // Scan cycles 0..39 for the ready pulse. Check its cycle index and the
  // result, then step past the DONE cycle.
  task automatic waitReady(input string tag, input int expLat, input logic [31:0] expQ,
                           input logic [31:0] expR, input bit dropReq, output int seenAt);
    int lat;
    lat    = -1;
    seenAt = -1;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (readyOut === 1'b1) begin
        lat    = k;
        seenAt = cycleCount;
      end
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".quotient"}, quotOut, expQ);
    checkOutput({tag, ".remainder"}, remOut, expR);
    @(posedge clk);
    #1;
    if (dropReq) req = 1'b0;
  endtask

  // Run one complete operation and release the request afterwards.
  task automatic applyStimulus(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic s, input int expLat, input logic [31:0] expQ,
                               input logic [31:0] expR);
    int t;
    driveOp(a, b, s);
    waitReady(tag, expLat, expQ, expR, 1'b1, t);
  endtask

  // Confirm that no ready pulse appears over a window of cycles.
  task automatic watchNoReady(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (readyOut !== 1'b0) seen++;
    end
    checkOutput(tag, 32'(seen), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Directed sequence.
  initial begin
    rst      = 1'b1;
    req      = 1'b0;
    flush    = 1'b0;
    signedIn = 1'b0;
    aIn      = '0;
    bIn      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset.ready", {31'b0, readyOut}, 32'd0);
    checkOutput("reset.quotient", quotOut, 32'd0);
    checkOutput("reset.remainder", remOut, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Normal-path arithmetic.
    applyStimulus("divu_100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);
    applyStimulus("divu_max_1", 32'hFFFFFFFF, 32'd1, 1'b0, 33, 32'hFFFFFFFF, 32'd0);
    applyStimulus("div_m7_2", 32'hFFFFFFF9, 32'd2, 1'b1, 33, 32'hFFFFFFFD, 32'hFFFFFFFF);
    applyStimulus("div_7_m2", 32'd7, 32'hFFFFFFFE, 1'b1, 33, 32'hFFFFFFFD, 32'd1);

    // Divide by zero and signed overflow.
    applyStimulus("div_by0_s", 32'h1234, 32'd0, 1'b1, 1, 32'hFFFFFFFF, 32'h1234);
    applyStimulus("div_by0_u", 32'h1234, 32'd0, 1'b0, 1, 32'hFFFFFFFF, 32'h1234);
    applyStimulus("div_by0_neg", 32'hFFFFFFFB, 32'd0, 1'b1, 1, 32'hFFFFFFFF, 32'hFFFFFFFB);
    applyStimulus("div_ovf_s", 32'h80000000, 32'hFFFFFFFF, 1'b1, 1, 32'h80000000, 32'd0);
    applyStimulus("div_zero_dividend", 32'd0, 32'd5, 1'b0, 33, 32'd0, 32'd0);
    applyStimulus("div_ovf_u", 32'h80000000, 32'hFFFFFFFF, 1'b0, 33, 32'd0, 32'h80000000);

    // Flush in cycle 10 of an operation.
    driveOp(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    req   = 1'b0;
    watchNoReady("flush.no_ready", 40);
    checkOutput("flush.quotient_held", quotOut, 32'd0);
    checkOutput("flush.remainder_held", remOut, 32'h80000000);
    @(posedge clk);
    #1;
    applyStimulus("after_flush_100_7", 32'd100, 32'd7, 1'b0, 33, 32'd14, 32'd2);

    // Request dropped in cycle 10 of an operation.
    driveOp(32'd1000, 32'd3, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    req = 1'b0;
    watchNoReady("drop.no_ready", 40);
    checkOutput("drop.quotient_held", quotOut, 32'd14);
    checkOutput("drop.remainder_held", remOut, 32'd2);
    @(posedge clk);
    #1;
    applyStimulus("after_drop_1000_3", 32'd1000, 32'd3, 1'b0, 33, 32'd333, 32'd1);

    // Reset in cycle 20 of an operation.
    driveOp(32'd100, 32'd7, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    checkOutput("midreset.ready", {31'b0, readyOut}, 32'd0);
    checkOutput("midreset.quotient", quotOut, 32'd0);
    checkOutput("midreset.remainder", remOut, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back operations after the reset.
    driveOp(32'd50, 32'd5, 1'b0);
    waitReady("b2b_50_5", 33, 32'd10, 32'd0, 1'b0, readyAt1);
    driveOp(32'd9, 32'd4, 1'b0);
    waitReady("b2b_9_4", 33, 32'd2, 32'd1, 1'b1, readyAt2);
    checkOutput("b2b.spacing", 32'(readyAt2 - readyAt1), 32'd34);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
